// File: rtl/proc_control_fsm.sv
// proc_control_fsm
//   Instruction-sequencing control unit for the simple processor datapath.
//   Latches an 8-bit instruction from DIN[7:0] during the fetch cycle and
//   steps a four-state FSM (T0..T3), decoding the bus-mux select and the
//   register/ALU control strobes combinationally from state and IR.
//
// Ports
//   Clock   in  1   rising-edge clock
//   Reset   in  1   asynchronous, active-high reset
//   Run     in  1   start request, sampled in T0 only
//   DIN     in  16  external data; [7:0] is the instruction when fetched
//   S       out 3   bus mux select (0..3 = R0..R3, DIN_SEL = DIN, G_SEL = G)
//   Rin     out 4   one-hot load enables for R0..R3
//   Ain     out 1   load enable for A
//   Gin     out 1   load enable for G
//   AddSub  out 1   ALU operation, 0 = add, 1 = subtract
//   IRin    out 1   instruction-fetch strobe
//   Done    out 1   final cycle of an instruction
//   Tstep   out 2   current state (0..3 for T0..T3)
module proc_control_fsm #(
    parameter logic [2:0] DIN_SEL = 3'd4,
    parameter logic [2:0] G_SEL   = 3'd5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] DIN,
    output logic [2:0]  S,
    output logic [3:0]  Rin,
    output logic        Ain,
    output logic        Gin,
    output logic        AddSub,
    output logic        IRin,
    output logic        Done,
    output logic [1:0]  Tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  ir_r;
    logic [2:0]  ir_op_s;
    logic [1:0]  ir_x_s;
    logic [1:0]  ir_y_s;
    logic        is_arith_s;
    logic        unused_s;

    // Register-number to one-hot load-enable decode.
    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    assign ir_op_s    = ir_r[7:5];
    assign ir_x_s     = ir_r[3:2];
    assign ir_y_s     = ir_r[1:0];
    assign is_arith_s = (ir_op_s == OP_ADD) || (ir_op_s == OP_SUB);
    // DIN[15:8] is data only and IR[4] is a don't-care field.
    assign unused_s   = &{1'b0, DIN[15:8], ir_r[4]};

    assign Tstep = state_r;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= T0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction register, written at the end of the fetch cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir_r <= 8'h00;
        end else if (IRin) begin
            ir_r <= DIN[7:0];
        end else begin
            ir_r <= ir_r;
        end
    end

    // Next-state logic: only add/sub continue past T1.
    always_comb begin
        state_next_s = T0;
        case (state_r)
            T0: begin
                if (Run) begin
                    state_next_s = T1;
                end else begin
                    state_next_s = T0;
                end
            end
            T1: begin
                if (is_arith_s) begin
                    state_next_s = T2;
                end else begin
                    state_next_s = T0;
                end
            end
            T2:      state_next_s = T3;
            T3:      state_next_s = T0;
            default: state_next_s = T0;
        endcase
    end

    // Output decode from state and IR; everything idles at DIN_SEL / zero.
    always_comb begin
        S      = DIN_SEL;
        Rin    = 4'b0000;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        IRin   = 1'b0;
        Done   = 1'b0;
        case (state_r)
            T0: begin
                IRin = Run;
            end
            T1: begin
                case (ir_op_s)
                    OP_MV: begin
                        S    = {1'b0, ir_y_s};
                        Rin  = reg_onehot(ir_x_s);
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        S    = DIN_SEL;
                        Rin  = reg_onehot(ir_x_s);
                        Done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        S   = {1'b0, ir_x_s};
                        Ain = 1'b1;
                    end
                    default: begin
                        // Undefined opcodes retire as a no-op.
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_arith_s) begin
                    S      = {1'b0, ir_y_s};
                    Gin    = 1'b1;
                    AddSub = ir_op_s[0];
                end else begin
                    S = DIN_SEL;
                end
            end
            T3: begin
                if (is_arith_s) begin
                    S    = G_SEL;
                    Rin  = reg_onehot(ir_x_s);
                    Done = 1'b1;
                end else begin
                    S = DIN_SEL;
                end
            end
            default: begin
                S = DIN_SEL;
            end
        endcase
    end

endmodule
